// File: rtl/avalon_s_pkg.sv
// Shared types for the round-robin Avalon-MM crossbar: FSM state encoding and
// the circular next-grant search used by every per-device arbiter.
// Pure declarations; no latency or backpressure of its own.
package avalon_s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERR
    } st_e;

    localparam int MAXN = 64;

    // First requester at or after ptr, wrapping at n; returns ptr if nobody requests.
    function automatic int rr_next(input logic [MAXN-1:0] req, input int n, input int ptr);
        int idx;
        int pick;
        pick = ptr;
        for (int i = MAXN - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/avalon_s_rr_arbiter.sv
// Per-device round-robin arbiter with grant lock and stall watchdog.
// Latency: grant registered one cycle after request; released the cycle after completion.
// Backpressure: holds the grant while the device stalls, until TIMEOUT stalled cycles.
module avalon_s_rr_arbiter
    import avalon_s_pkg::*;
#(
    parameter int  NH      = 3,
    parameter int  TIMEOUT = 256,
    localparam int HW      = (NH > 1) ? $clog2(NH) : 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NH-1:0] req_i,
    input  logic          dev_wait_i,
    output logic          busy_o,
    output logic [HW-1:0] grant_o,
    output logic          timeout_o
);

    localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    st_e           state_q;
    logic [HW-1:0] grant_q;
    logic [HW-1:0] rr_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] pick_d;
    logic [HW-1:0] rr_d;
    logic          done_d;

    assign pick_d    = HW'(rr_next(MAXN'(req_i), NH, int'(rr_q)));
    assign rr_d      = (grant_q == HW'(NH - 1)) ? '0 : grant_q + HW'(1);
    assign busy_o    = (state_q == ST_BUSY);
    assign grant_o   = grant_q;
    assign timeout_o = (TIMEOUT > 0) && busy_o && req_i[grant_q] && dev_wait_i && (cnt_q == LIMIT);
    // Host abandoning the request also frees the device, without an error.
    assign done_d    = !req_i[grant_q] || !dev_wait_i || timeout_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        state_q <= ST_BUSY;
                        grant_q <= pick_d;
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (done_d) begin
                        state_q <= ST_IDLE;
                        rr_q    <= rr_d;
                    end else if (dev_wait_i) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/avalon_s_crossbar_rr.sv
// NH-host x ND-device Avalon-MM crossbar: address decode, muxing, unmapped/timeout errors.
// Latency: 1-cycle arbitration, then device readdata/waitrequest pass straight back to the host.
// Backpressure: losing or arbitrating hosts see waitrequest=1; the granted host sees the device's.
module avalon_s_crossbar_rr
    import avalon_s_pkg::*;
#(
    parameter int            NH       = 3,
    parameter int            ND       = 2,
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            TIMEOUT  = 256,
    parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ND-1:0][AW-1:0]   devices_address_low,
    input  logic [ND-1:0][AW-1:0]   devices_address_high,
    input  logic [NH-1:0]           hosts_avn_read,
    input  logic [NH-1:0]           hosts_avn_write,
    input  logic [NH-1:0][AW-1:0]   hosts_avn_address,
    input  logic [NH-1:0][DW/8-1:0] hosts_avn_byte_enable,
    input  logic [NH-1:0][DW-1:0]   hosts_avn_writedata,
    output logic [NH-1:0][DW-1:0]   hosts_avn_readdata,
    output logic [NH-1:0]           hosts_avn_waitrequest,
    output logic [ND-1:0]           devices_avn_read,
    output logic [ND-1:0]           devices_avn_write,
    output logic [ND-1:0][AW-1:0]   devices_avn_address,
    output logic [ND-1:0][DW/8-1:0] devices_avn_byte_enable,
    output logic [ND-1:0][DW-1:0]   devices_avn_writedata,
    input  logic [ND-1:0][DW-1:0]   devices_avn_readdata,
    input  logic [ND-1:0]           devices_avn_waitrequest,
    output logic                    bus_error,
    output logic [AW-1:0]           bus_error_address
);

    localparam int HW  = (NH > 1) ? $clog2(NH) : 1;
    localparam int DSW = (ND > 1) ? $clog2(ND) : 1;

    logic [NH-1:0]          req;
    logic [NH-1:0]          mapped;
    logic [NH-1:0]          err_h;
    logic [NH-1:0][DSW-1:0] dsel;
    logic [ND-1:0][NH-1:0]  dev_req;
    logic [ND-1:0]          busy;
    logic [ND-1:0]          tmo;
    logic [ND-1:0][HW-1:0]  gnt;
    st_e                    hst_q [NH];
    logic [AW-1:0]          err_addr;
    logic [AW-1:0]          bea_q;

    // Requests are masked during reset so every host output shows its reset value.
    always_comb begin
        req    = (hosts_avn_read | hosts_avn_write) & {NH{rst_n}};
        mapped = '0;
        dsel   = '0;
        for (int h = 0; h < NH; h++) begin
            for (int d = ND - 1; d >= 0; d--) begin
                if (hosts_avn_address[h] >= devices_address_low[d] &&
                    hosts_avn_address[h] <= devices_address_high[d]) begin
                    mapped[h] = 1'b1;
                    dsel[h]   = DSW'(d);
                end
            end
        end
    end

    always_comb begin
        dev_req = '0;
        for (int d = 0; d < ND; d++) begin
            for (int h = 0; h < NH; h++) begin
                dev_req[d][h] = req[h] && mapped[h] && (dsel[h] == DSW'(d));
            end
        end
    end

    for (genvar d = 0; d < ND; d++) begin : g_arb
        avalon_s_rr_arbiter #(
            .NH      (NH),
            .TIMEOUT (TIMEOUT)
        ) u_arb (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_i      (dev_req[d]),
            .dev_wait_i (devices_avn_waitrequest[d]),
            .busy_o     (busy[d]),
            .grant_o    (gnt[d]),
            .timeout_o  (tmo[d])
        );
    end

    always_comb begin
        devices_avn_read        = '0;
        devices_avn_write       = '0;
        devices_avn_address     = '0;
        devices_avn_byte_enable = '0;
        devices_avn_writedata   = '0;
        for (int d = 0; d < ND; d++) begin
            if (busy[d]) begin
                devices_avn_read[d]        = hosts_avn_read[gnt[d]] && rst_n && !tmo[d];
                devices_avn_write[d]       = hosts_avn_write[gnt[d]] && rst_n && !tmo[d];
                devices_avn_address[d]     = hosts_avn_address[gnt[d]];
                devices_avn_byte_enable[d] = hosts_avn_byte_enable[gnt[d]];
                devices_avn_writedata[d]   = hosts_avn_writedata[gnt[d]];
            end
        end
    end

    always_comb begin
        hosts_avn_waitrequest = '0;
        hosts_avn_readdata    = '0;
        err_h                 = '0;
        for (int h = 0; h < NH; h++) begin
            if (req[h]) begin
                if (!mapped[h]) begin
                    if (hst_q[h] == ST_ERR) begin
                        hosts_avn_readdata[h] = ERR_DATA;
                        err_h[h]              = 1'b1;
                    end else begin
                        hosts_avn_waitrequest[h] = 1'b1;
                    end
                end else if (busy[dsel[h]] && gnt[dsel[h]] == HW'(h)) begin
                    if (tmo[dsel[h]]) begin
                        hosts_avn_readdata[h] = ERR_DATA;
                        err_h[h]              = 1'b1;
                    end else begin
                        hosts_avn_waitrequest[h] = devices_avn_waitrequest[dsel[h]];
                        hosts_avn_readdata[h]    = devices_avn_readdata[dsel[h]];
                    end
                end else begin
                    hosts_avn_waitrequest[h] = 1'b1;
                end
            end
        end
    end

    // Descending scan leaves the lowest-index erroring host's address.
    always_comb begin
        err_addr = '0;
        for (int h = NH - 1; h >= 0; h--) begin
            if (err_h[h]) begin
                err_addr = hosts_avn_address[h];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int h = 0; h < NH; h++) begin
                hst_q[h] <= ST_IDLE;
            end
            bea_q <= '0;
        end else begin
            for (int h = 0; h < NH; h++) begin
                case (hst_q[h])
                    ST_IDLE: if (req[h] && !mapped[h]) hst_q[h] <= ST_ERR;
                    default: hst_q[h] <= ST_IDLE;
                endcase
            end
            if (|err_h) begin
                bea_q <= err_addr;
            end
        end
    end

    assign bus_error         = |err_h;
    assign bus_error_address = bea_q;

endmodule

// File: tb/tb_avalon_s_crossbar_rr.sv
// Directed bench for avalon_s_crossbar_rr: 3 hosts, RAM at 0x0000_0000 and an
// address-echo device at 0x1000_0000, watchdog limit 8.
module tb_avalon_s_crossbar_rr;

    localparam int NH = 3;
    localparam int ND = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                    clk;
    logic                    rst_n;
    logic [ND-1:0][AW-1:0]   dlow;
    logic [ND-1:0][AW-1:0]   dhigh;
    logic [NH-1:0]           hrd;
    logic [NH-1:0]           hwr;
    logic [NH-1:0][AW-1:0]   haddr;
    logic [NH-1:0][3:0]      hbe;
    logic [NH-1:0][DW-1:0]   hwd;
    logic [NH-1:0][DW-1:0]   hrdata;
    logic [NH-1:0]           hwait;
    logic [ND-1:0]           drd_s;
    logic [ND-1:0]           dwr_s;
    logic [ND-1:0][AW-1:0]   daddr;
    logic [ND-1:0][3:0]      dbe;
    logic [ND-1:0][DW-1:0]   dwd;
    logic [ND-1:0][DW-1:0]   drdata;
    logic [ND-1:0]           dwait;
    logic                    berr;
    logic [AW-1:0]           beaddr;

    logic [31:0] mem [16];
    int          errors  = 0;
    int          checks  = 0;
    int          rd0_cnt = 0;
    int          base;
    logic [2:0]  rr_w [8];
    int          rr_g [8];

    avalon_s_crossbar_rr #(
        .NH       (NH),
        .ND       (ND),
        .AW       (AW),
        .DW       (DW),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .devices_address_low     (dlow),
        .devices_address_high    (dhigh),
        .hosts_avn_read          (hrd),
        .hosts_avn_write         (hwr),
        .hosts_avn_address       (haddr),
        .hosts_avn_byte_enable   (hbe),
        .hosts_avn_writedata     (hwd),
        .hosts_avn_readdata      (hrdata),
        .hosts_avn_waitrequest   (hwait),
        .devices_avn_read        (drd_s),
        .devices_avn_write       (dwr_s),
        .devices_avn_address     (daddr),
        .devices_avn_byte_enable (dbe),
        .devices_avn_writedata   (dwd),
        .devices_avn_readdata    (drdata),
        .devices_avn_waitrequest (dwait),
        .bus_error               (berr),
        .bus_error_address       (beaddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign drdata[0] = mem[daddr[0][5:2]];
    assign drdata[1] = daddr[1] ^ 32'h5A5A_0000;

    always @(negedge clk) begin
        if (drd_s[0]) rd0_cnt++;
        if (dwr_s[0] && !dwait[0]) begin
            for (int b = 0; b < 4; b++) begin
                if (dbe[0][b]) mem[daddr[0][5:2]][8*b +: 8] = dwd[0][8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        dlow[0]  = 32'h0000_0000;
        dhigh[0] = 32'h0000_0FFF;
        dlow[1]  = 32'h1000_0000;
        dhigh[1] = 32'h1000_0FFF;
        hrd = '0; hwr = '0; haddr = '0; hbe = '1; hwd = '0;
        dwait = '0; rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
        rr_w = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011, 3'b111, 3'b110};
        rr_g = '{-1, 0, -1, 1, -1, 2, -1, 0};

        // Reset state
        repeat (2) tick();
        settle();
        chk("rst_hwait", 32'(hwait), 32'h0);
        chk("rst_dev_strobe", 32'({dwr_s, drd_s}), 32'h0);
        chk("rst_berr", 32'(berr), 32'h0);
        chk("rst_bea", beaddr, 32'h0);
        chk("rst_daddr0", daddr[0], 32'h0);
        tick();
        rst_n = 1'b1;

        // Three hosts hammer device 0: grants 0,1,2,0 with an idle cycle between
        hrd = 3'b111;
        haddr[0] = 32'h0; haddr[1] = 32'h4; haddr[2] = 32'h8;
        base = rd0_cnt;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("rr_wait_c%0d", k), 32'(hwait), 32'(rr_w[k]));
            if (rr_g[k] >= 0) chk($sformatf("rr_data_c%0d", k), hrdata[rr_g[k]], 32'hA000_0000 + 32'(rr_g[k]));
            tick();
        end
        hrd = '0;
        settle();
        chk("rr_strobes", 32'(rd0_cnt - base), 32'd4);

        // Single zero-wait read of 0x10
        tick();
        hrd = 3'b001; haddr[0] = 32'h10;
        base = rd0_cnt;
        settle();
        chk("rd_wait_c0", 32'(hwait[0]), 32'h1);
        chk("rd_devrd_c0", 32'(drd_s[0]), 32'h0);
        tick();
        settle();
        chk("rd_wait_c1", 32'(hwait[0]), 32'h0);
        chk("rd_data", hrdata[0], 32'hA000_0004);
        chk("rd_daddr", daddr[0], 32'h10);
        tick();
        hrd = '0;
        settle();
        chk("rd_devrd_c2", 32'(drd_s[0]), 32'h0);
        chk("rd_strobes", 32'(rd0_cnt - base), 32'd1);

        // Byte-enabled write to 0x20, then read back
        tick();
        hwr = 3'b001; haddr[0] = 32'h20; hwd[0] = 32'h1234_5678; hbe[0] = 4'b0101;
        settle();
        chk("wr_wait_c0", 32'(hwait[0]), 32'h1);
        tick();
        settle();
        chk("wr_devwr", 32'(dwr_s[0]), 32'h1);
        chk("wr_wdata", dwd[0], 32'h1234_5678);
        chk("wr_be", 32'(dbe[0]), 32'h5);
        chk("wr_wait_c1", 32'(hwait[0]), 32'h0);
        tick();
        hwr = '0; hrd = 3'b001; hbe[0] = 4'hF;
        settle();
        chk("wr_rb_wait_c0", 32'(hwait[0]), 32'h1);
        tick();
        settle();
        chk("wr_rb_data", hrdata[0], 32'hA034_0078);
        tick();
        hrd = '0;

        // Unmapped read by host 1
        tick();
        hrd = 3'b010; haddr[1] = 32'hF000_0000;
        settle();
        chk("um_wait_c0", 32'(hwait[1]), 32'h1);
        chk("um_berr_c0", 32'(berr), 32'h0);
        tick();
        settle();
        chk("um_wait_c1", 32'(hwait[1]), 32'h0);
        chk("um_data", hrdata[1], 32'hDEAD_BEEF);
        chk("um_berr_c1", 32'(berr), 32'h1);
        chk("um_no_strobe", 32'({dwr_s, drd_s}), 32'h0);
        tick();
        hrd = '0;
        settle();
        chk("um_berr_c2", 32'(berr), 32'h0);
        chk("um_bea", beaddr, 32'hF000_0000);

        // Host 0 -> device 0 and host 2 -> device 1 in parallel
        tick();
        hrd = 3'b101; haddr[0] = 32'h14; haddr[2] = 32'h1000_0040;
        settle();
        chk("par_wait_c0", 32'(hwait), 32'h5);
        tick();
        settle();
        chk("par_wait_c1", 32'(hwait), 32'h0);
        chk("par_strobes", 32'(drd_s), 32'h3);
        chk("par_data0", hrdata[0], 32'hA000_0005);
        chk("par_data2", hrdata[2], 32'h4A5A_0040);
        chk("par_daddr1", daddr[1], 32'h1000_0040);
        tick();
        hrd = '0;

        // Watchdog: device 0 stalls forever, host 1 times out on the 8th BUSY cycle
        tick();
        dwait[0] = 1'b1; hrd = 3'b010; haddr[1] = 32'h18;
        base = rd0_cnt;
        settle();
        chk("wd_wait_c0", 32'(hwait[1]), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            settle();
            chk($sformatf("wd_wait_c%0d", k), 32'(hwait[1]), (k < 8) ? 32'h1 : 32'h0);
            chk($sformatf("wd_devrd_c%0d", k), 32'(drd_s[0]), (k < 8) ? 32'h1 : 32'h0);
        end
        chk("wd_data", hrdata[1], 32'hDEAD_BEEF);
        chk("wd_berr", 32'(berr), 32'h1);
        tick();
        hrd = '0;
        settle();
        chk("wd_bea", beaddr, 32'h18);
        chk("wd_strobes", 32'(rd0_cnt - base), 32'd7);
        tick();
        dwait[0] = 1'b0; hrd = 3'b010;
        settle();
        chk("wd_next_wait_c0", 32'(hwait[1]), 32'h1);
        tick();
        settle();
        chk("wd_next_wait_c1", 32'(hwait[1]), 32'h0);
        chk("wd_next_data", hrdata[1], 32'hA000_0006);
        tick();
        hrd = '0;

        // Reset during a stalled BUSY transaction
        tick();
        dwait[0] = 1'b1; hrd = 3'b001; haddr[0] = 32'h0;
        tick();
        settle();
        chk("rs_devrd_busy", 32'(drd_s[0]), 32'h1);
        tick();
        rst_n = 1'b0;
        settle();
        chk("rs_berr_in", 32'(berr), 32'h0);
        tick();
        settle();
        chk("rs_devrd", 32'(drd_s[0]), 32'h0);
        chk("rs_hwait", 32'(hwait[0]), 32'h0);
        chk("rs_berr", 32'(berr), 32'h0);
        chk("rs_bea", beaddr, 32'h0);
        rst_n = 1'b1; hrd = '0; dwait = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
